// File: rtl/ex_stage.sv
// ex_stage: LoongArch execute stage -- ALU, data-SRAM request and forwarding bundle.
// Define ES_PERF_CNT_EN to add the es_inst_cnt / es_stall_cnt performance counters.
module ex_stage #(
    parameter int DS2ES_W = 148,
    parameter int ES2MS_W = 71
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ds2es_valid,
    input  logic [DS2ES_W-1:0] ds2es_bus,
    output logic               es_allowin,
    output logic               es2ms_valid,
    output logic [ES2MS_W-1:0] es2ms_bus,
    input  logic               ms_allowin,
    output logic [38:0]        es_rf_zip,
    output logic               data_sram_en,
    output logic [3:0]         data_sram_we,
    output logic [31:0]        data_sram_addr,
    output logic [31:0]        data_sram_wdata
`ifdef ES_PERF_CNT_EN
    ,
    output logic [31:0]        es_inst_cnt,
    output logic [31:0]        es_stall_cnt
`endif
);
    logic               es_valid;
    logic               es_ready_go;
    logic               fire;
    logic [DS2ES_W-1:0] bus_r;
    logic [11:0]        alu_op;
    logic               res_from_mem;
    logic               mem_we;
    logic               rf_we;
    logic [4:0]         rf_waddr;
    logic [31:0]        src1;
    logic [31:0]        src2;
    logic [31:0]        rkd_value;
    logic [31:0]        pc;
    logic [31:0]        alu_result;
    logic               slt_lt;
    logic               sltu_lt;

    assign {alu_op, res_from_mem, src1, src2, mem_we, rf_we, rf_waddr, rkd_value, pc} = bus_r;

    assign es_ready_go = 1'b1;
    assign es_allowin  = ~es_valid | (es_ready_go & ms_allowin);
    assign es2ms_valid = es_valid & es_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid <= 1'b0;
            bus_r    <= '0;
        end else begin
            if (es_allowin)
                es_valid <= ds2es_valid;
            if (ds2es_valid && es_allowin)
                bus_r <= ds2es_bus;
        end
    end

    assign slt_lt  = $signed(src1) < $signed(src2);
    assign sltu_lt = src1 < src2;

    // One-hot select: an all-zero alu_op falls through to 0.
    assign alu_result = ({32{alu_op[0]}}  & (src1 + src2))
                      | ({32{alu_op[1]}}  & (src1 - src2))
                      | ({32{alu_op[2]}}  & {31'b0, slt_lt})
                      | ({32{alu_op[3]}}  & {31'b0, sltu_lt})
                      | ({32{alu_op[4]}}  & (src1 & src2))
                      | ({32{alu_op[5]}}  & ~(src1 | src2))
                      | ({32{alu_op[6]}}  & (src1 | src2))
                      | ({32{alu_op[7]}}  & (src1 ^ src2))
                      | ({32{alu_op[8]}}  & (src1 << src2[4:0]))
                      | ({32{alu_op[9]}}  & (src1 >> src2[4:0]))
                      | ({32{alu_op[10]}} & 32'($signed(src1) >>> src2[4:0]))
                      | ({32{alu_op[11]}} & src2);

    // Request only in the handoff cycle so a stalled store writes exactly once.
    assign fire            = es_valid & ms_allowin;
    assign data_sram_en    = fire & (res_from_mem | mem_we);
    assign data_sram_we    = {4{fire & mem_we}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd_value;

    assign es2ms_bus = {res_from_mem, rf_we & es_valid, rf_waddr, alu_result, pc};
    assign es_rf_zip = {res_from_mem & es_valid, rf_we & es_valid, rf_waddr, alu_result};

`ifdef ES_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_inst_cnt  <= '0;
            es_stall_cnt <= '0;
        end else begin
            if (es2ms_valid && ms_allowin)
                es_inst_cnt <= es_inst_cnt + 32'd1;
            if (es_valid && !ms_allowin)
                es_stall_cnt <= es_stall_cnt + 32'd1;
        end
    end
`endif
endmodule
